mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM pipeline stage: the consumer end of the EX-stage outputs (ALU result, forwarded store data, funct3, control bits).
- Registers the EX/MEM boundary and drives a req/ack data-memory port with byte enables.
- Aligns and sign/zero-extends load data, and registers the MEM/WB boundary.
- Returns ALU_DATA_MEM to the EX forwarding muxes and asserts a pipeline stall while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles waiting for mem_ack before abort with bus error (≥2).
- TO_W, 5, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- ALU_OUT_EX  in  32  address or ALU result from EX.
- REG_DATA2_EX_FINAL  in  32  forwarded store data from EX.
- FUNCT3_EX  in  3  access size/sign.
- RD_EX  in  5  destination register.
- RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX  in  1 each  control from EX.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word address, bits[1:0]=0.
- mem_wdata  out  32  lane-shifted store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  request completion.
- mem_rdata  in  32  read word, valid with mem_ack.
- stall_mem  out  1  freeze IF/ID/EX and EX/MEM register.
- ALU_DATA_MEM  out  32  ALU result held in MEM, to EX forwarding.
- RD_MEM, RegWrite_MEM  out  5/1  to forwarding unit.
- WB_DATA  out  32  selected write-back value.
- RD_WB, RegWrite_WB  out  5/1  to register file and forwarding.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all EX/MEM and MEM/WB registers 0, FSM IDLE, counter 0. All outputs 0.
- EX/MEM register:
  - Loads every cycle that stall_mem=0.
  - Holds while stall_mem=1.
  - ALU_DATA_MEM, RD_MEM and RegWrite_MEM come straight from it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Non-memory op: MEM/WB loads next edge (1-cycle latency), WB_DATA=ALU result.
  - MemRead or MemWrite latched: mem_req=1 combinationally, stall_mem=1, go to ACCESS.
- ACCESS:
  - mem_req and address/data/be held stable until mem_ack.
  - Counter increments each cycle.
  - mem_ack in the first cycle is legal (zero wait).
  - mem_ack → DONE, load data captured.
  - Counter reaches TIMEOUT with no ack → bus_err pulse, RegWrite_WB forced 0, go to DONE.
- DONE:
  - stall_mem=0 for one cycle, MEM/WB loaded, EX/MEM advances, then IDLE.
  - mem_req=0 in DONE.
- Store byte lanes, off=addr[1:0]:
  - SB (000): be=1<<off, wdata=byte replicated ×4.
  - SH (001): be=0011 or 1100 per addr[1], half replicated ×2.
  - SW (010): be=1111.
- Loads:
  - Byte/half selected by off.
  - LB/LH sign-extend; LBU (100)/LHU (101) zero-extend; LW passthrough.
  - WB_DATA = MemtoReg ? aligned load : ALU result.
- Misalignment (macro off): low address bits ignored for LH/SH (addr[0]) and LW/SW (addr[1:0]).
- Reset asserted mid-ACCESS: mem_req drops immediately (async), no WB update.
- Both MemRead and MemWrite set: treated as a write.
- Undefined funct3 on a store: be=0000, req still issued.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- With it:
  - Adds output misalign 1 bit.
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0: no mem_req issued, misalign pulses for 1 cycle, RegWrite_WB=0, 1-cycle pass-through, no stall.
- Without it: port absent, alignment silently ignored as above.

Decomposition:
- Shared package rv_mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding, lane-select helper constants.
- One sub-module, load_align_ext: combinational rdata+off+funct3 → 32-bit extended value.
- Store lane logic stays inline.

Test Plan:
- ALU op, RegWrite_EX=1, RD_EX=5, ALU_OUT_EX=0x1234 → next cycle ALU_DATA_MEM=0x1234; following cycle WB_DATA=0x1234, RD_WB=5, stall_mem never high.
- SB addr 0x103, data 0xAB → mem_addr=0x100, be=1000, wdata=0xABABABAB; ack after 3 cycles → stall_mem high exactly 3 cycles.
- LB addr 0x102, rdata 0x00800000, ack at cycle 0 → WB_DATA=0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102, rdata 0xBEEF0000 → 0x0000BEEF.
- LW, no ack for TIMEOUT=16 cycles → bus_err single pulse, RegWrite_WB=0, stall releases, pipeline resumes.
- rst_n low during ACCESS → mem_req 0 immediately; after release state IDLE, all outputs 0.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x101 → no mem_req, misalign=1 one cycle, RegWrite_WB=0.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: funct3 codes, MEM FSM encoding, byte-lane constants and
// the EX/MEM bundle shared by the MEM stage and its load aligner.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
  } ex_mem_t;

  // Size is carried in funct3[1:0] for both loads and stores.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (f3[1:0] == 2'b01): m = off[0];
      (f3[1:0] == 2'b10): m = |off;
      default:            m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: selects the addressed byte/half of a read word and
// sign- or zero-extends it; words pass through untouched.
module load_align_ext
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    unique case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'd0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM and MEM/WB registers around a req/ack data port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses (misalign out).
module mem_access_stage
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALU_OUT_EX,
  input  logic [31:0] REG_DATA2_EX_FINAL,
  input  logic [2:0]  FUNCT3_EX,
  input  logic [4:0]  RD_EX,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_mem,
  output logic [31:0] ALU_DATA_MEM,
  output logic [4:0]  RD_MEM,
  output logic        RegWrite_MEM,
  output logic [31:0] WB_DATA,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        bus_err
);

  ex_mem_t     em;
  ex_mem_t     ex_in;
  logic [1:0]  state;
  logic [TO_W-1:0] cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] wb_data_q;
  logic [4:0]  rd_wb_q;
  logic        rw_wb_q;
  logic        mem_op;
  logic        mis;
  logic        go;
  logic        wb_en;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld_ext;

  assign ex_in = '{
    alu:      ALU_OUT_EX,
    sdata:    REG_DATA2_EX_FINAL,
    funct3:   FUNCT3_EX,
    rd:       RD_EX,
    regwrite: RegWrite_EX,
    memtoreg: MemtoReg_EX,
    memread:  MemRead_EX,
    memwrite: MemWrite_EX
  };

  assign off    = em.alu[1:0];
  assign mem_op = em.memread | em.memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis      = mem_op & misaligned(em.funct3, off);
  assign misalign = (state == S_IDLE) & mis;
`else
  assign mis = 1'b0;
`endif

  assign go        = mem_op & ~mis;
  assign mem_req   = ((state == S_IDLE) & go) | (state == S_ACCESS);
  assign stall_mem = mem_req;
  assign wb_en     = ((state == S_IDLE) & ~go) | (state == S_DONE);

  always_comb begin
    be    = BE_NONE;
    wdata = em.sdata;
    unique case (em.funct3[1:0])
      2'b00: begin
        be    = BE_B0 << off;
        wdata = {4{em.sdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? BE_HI : BE_LO;
        wdata = {2{em.sdata[15:0]}};
      end
      2'b10:   be = BE_ALL;
      default: be = BE_NONE;
    endcase
    // Unsigned sizes have no store form: issue the write with no lanes.
    if (em.memwrite && em.funct3[2]) begin
      be    = BE_NONE;
      wdata = em.sdata;
    end
  end

  assign mem_we    = mem_req & em.memwrite;
  assign mem_addr  = {em.alu[31:2], 2'b00};
  assign mem_be    = mem_req ? be : BE_NONE;
  assign mem_wdata = mem_we ? wdata : 32'd0;

  load_align_ext u_align (
    .rdata  (rdata_q),
    .off    (off),
    .funct3 (em.funct3),
    .data   (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go && mem_ack) begin
            state   <= S_DONE;
            rdata_q <= mem_rdata;
          end else if (go) begin
            state <= S_ACCESS;
            cnt   <= TO_W'(1);
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            state   <= S_DONE;
            rdata_q <= mem_rdata;
            cnt     <= '0;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            state <= S_DONE;
            err_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em        <= '0;
      wb_data_q <= '0;
      rd_wb_q   <= '0;
      rw_wb_q   <= 1'b0;
    end else begin
      if (!stall_mem) em <= ex_in;
      if (wb_en) begin
        wb_data_q <= em.memtoreg ? ld_ext : em.alu;
        rd_wb_q   <= em.rd;
        rw_wb_q   <= em.regwrite & ~err_q & ~mis;
      end
    end
  end

  assign ALU_DATA_MEM = em.alu;
  assign RD_MEM       = em.rd;
  assign RegWrite_MEM = em.regwrite;
  assign WB_DATA      = wb_data_q;
  assign RD_WB        = rd_wb_q;
  assign RegWrite_WB  = rw_wb_q;
  assign bus_err      = err_q;

endmodule
